// File: rtl/snake_pkg.sv
// Shared game-progress types and widths for the score tracker and Scoreboard.
package snake_pkg;

  localparam int SIZE_W  = 8;
  localparam int LEVEL_W = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAYING   = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  function automatic logic [SIZE_W-1:0] size_max(input logic [SIZE_W-1:0] a,
                                                 input logic [SIZE_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_edge_detect.sv
// Brings the slow screen clock into the system clock domain and emits a
// one-cycle pulse on each of its rising edges.
module tick_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic tick
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= raw;
      sync <= meta;
      prev <= sync;
    end
  end

  assign tick = sync & ~prev;

endmodule

// File: rtl/snake_score_tracker.sv
// Turns apple/collision/start events into size, level and gameOver for Scoreboard.
// Optional best-size register enabled by defining SCORE_HIGHSCORE_EN.
//
// state     | meaning
// IDLE      | after reset, waiting for the first startGame
// PLAYING   | game running, apples grow the snake and advance levels
// GAME_OVER | game ended, restart locked out for GAMEOVER_TICKS screen ticks
module snake_score_tracker
  import snake_pkg::*;
#(
  parameter int START_SIZE       = 1,
  parameter int MAX_SIZE         = 255,
  parameter int APPLES_PER_LEVEL = 8,
  parameter int MAX_LEVEL        = 7,
  parameter int GAMEOVER_TICKS   = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               screenClock,
  input  logic               startGame,
  input  logic               appleEaten,
  input  logic               collision,
  input  logic               debugMode,
  output logic [SIZE_W-1:0]  size,
  output logic [LEVEL_W-1:0] level,
  output logic               gameOver,
  output logic               levelUp,
  output logic [SIZE_W-1:0]  highSize
);

  localparam int APPLE_W = $clog2(APPLES_PER_LEVEL + 1);
  localparam int HOLD_W  = $clog2(GAMEOVER_TICKS + 1);

  localparam logic [SIZE_W-1:0]  START_SZ    = SIZE_W'(START_SIZE);
  localparam logic [SIZE_W-1:0]  MAX_SZ      = SIZE_W'(MAX_SIZE);
  localparam logic [LEVEL_W-1:0] MAX_LVL     = LEVEL_W'(MAX_LEVEL);
  localparam logic [APPLE_W-1:0] APPLE_LAST  = APPLE_W'(APPLES_PER_LEVEL - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX    = HOLD_W'(GAMEOVER_TICKS);

  state_t             state;
  logic [APPLE_W-1:0] apple_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic               tick;
  logic               hit;
  logic [SIZE_W-1:0]  size_inc;
  logic               max_hit;

  tick_edge_detect u_tick (
    .clock (clock),
    .reset (reset),
    .raw   (screenClock),
    .tick  (tick)
  );

  assign hit      = collision & ~debugMode;
  assign size_inc = size + 1'b1;
  assign max_hit  = appleEaten && (size_inc == MAX_SZ);

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      size      <= START_SZ;
      level     <= '0;
      apple_cnt <= '0;
      hold_cnt  <= '0;
      gameOver  <= 1'b0;
      levelUp   <= 1'b0;
    end else begin
      levelUp <= 1'b0;
      unique case (state)
        IDLE: begin
          if (startGame) begin
            state     <= PLAYING;
            size      <= START_SZ;
            level     <= '0;
            apple_cnt <= '0;
          end
        end
        PLAYING: begin
          // A real collision wins over an apple eaten in the same cycle.
          if (hit) begin
            state    <= GAME_OVER;
            gameOver <= 1'b1;
            hold_cnt <= '0;
          end else if (appleEaten) begin
            if (size != MAX_SZ) size <= size_inc;
            if (max_hit) begin
              state    <= GAME_OVER;
              gameOver <= 1'b1;
              hold_cnt <= '0;
            end
            if (apple_cnt == APPLE_LAST) begin
              apple_cnt <= '0;
              if (level != MAX_LVL) begin
                level   <= level + 1'b1;
                levelUp <= 1'b1;
              end
            end else begin
              apple_cnt <= apple_cnt + 1'b1;
            end
          end
        end
        GAME_OVER: begin
          if (tick && (hold_cnt != HOLD_MAX)) hold_cnt <= hold_cnt + 1'b1;
          if (startGame && (hold_cnt == HOLD_MAX)) begin
            state     <= PLAYING;
            gameOver  <= 1'b0;
            size      <= START_SZ;
            level     <= '0;
            apple_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCORE_HIGHSCORE_EN
  logic [SIZE_W-1:0] end_size;

  assign end_size = hit ? size : size_inc;

  always_ff @(posedge clock) begin
    if (!reset) begin
      highSize <= '0;
    end else if ((state == PLAYING) && (hit || max_hit)) begin
      highSize <= size_max(highSize, end_size);
    end
  end
`else
  assign highSize = '0;
`endif

endmodule
